// File: rtl/sd_cmd_sequencer.sv
// Runs one SD-card SPI-mode transaction (command, R1 poll, optional single-block read)
// by driving a byte-wide SPI shifter with one byte in flight at a time.
module sd_cmd_sequencer #(
  parameter int unsigned R1_POLL     = 8,
  parameter logic [15:0] TOKEN_POLL  = 16'd4096,
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        read_block,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [7:0]  r1,
  output logic [15:0] crc16,
  output logic        ss_req,
  output logic        buf_we,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        sh_wr_req,
  output logic [7:0]  sh_wdata,
  output logic        sh_rd_req,
  input  logic        sh_in_full,
  input  logic        sh_out_full,
  input  logic [7:0]  sh_rdata
);

  typedef enum logic [3:0] {
    StIdle, StPre, StCmd, StR1, StToken, StData, StCrc, StPost, StFin
  } state_e;

  // Each byte exchange walks write -> read -> process.
  typedef enum logic [1:0] {XWr, XRd, XProc} xphase_e;

  state_e      state_q;
  xphase_e     xph_q;
  logic [5:0]  cmd_idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        rd_blk_q;
  logic [2:0]  byte_cnt_q;
  logic [3:0]  r1_cnt_q;
  logic [15:0] tok_cnt_q;
  logic [8:0]  data_cnt_q;
  logic [7:0]  rx_q;
  logic        abort_pend_q;
  logic        abort_now;
  logic [7:0]  cmd_byte;
  logic [7:0]  tx_byte;

  assign abort_now = abort | abort_pend_q;

  always_comb begin
    cmd_byte = 8'hFF;
    case (byte_cnt_q)
      3'd0:    cmd_byte = {2'b01, cmd_idx_q};
      3'd1:    cmd_byte = arg_q[31:24];
      3'd2:    cmd_byte = arg_q[23:16];
      3'd3:    cmd_byte = arg_q[15:8];
      3'd4:    cmd_byte = arg_q[7:0];
      3'd5:    cmd_byte = {crc_q, 1'b1};
      default: cmd_byte = 8'hFF;
    endcase
    tx_byte = (state_q == StCmd) ? cmd_byte : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      xph_q        <= XWr;
      cmd_idx_q    <= '0;
      arg_q        <= '0;
      crc_q        <= '0;
      rd_blk_q     <= 1'b0;
      byte_cnt_q   <= '0;
      r1_cnt_q     <= '0;
      tok_cnt_q    <= '0;
      data_cnt_q   <= '0;
      rx_q         <= '0;
      abort_pend_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= 3'd0;
      r1           <= 8'hFF;
      crc16        <= 16'h0000;
      ss_req       <= 1'b0;
      buf_we       <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= '0;
      sh_wr_req    <= 1'b0;
      sh_wdata     <= '0;
      sh_rd_req    <= 1'b0;
    end else begin
      done      <= 1'b0;
      sh_wr_req <= 1'b0;
      sh_rd_req <= 1'b0;
      buf_we    <= 1'b0;
      // Abort is remembered so an in-flight read can drain before leaving.
      if (abort && state_q != StIdle && state_q != StPost && state_q != StFin) begin
        abort_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            cmd_idx_q    <= cmd_index;
            arg_q        <= cmd_arg;
            crc_q        <= cmd_crc;
            rd_blk_q     <= read_block;
            busy         <= 1'b1;
            ss_req       <= 1'b1;
            status       <= 3'd0;
            r1           <= 8'hFF;
            abort_pend_q <= 1'b0;
            byte_cnt_q   <= '0;
            r1_cnt_q     <= '0;
            tok_cnt_q    <= '0;
            data_cnt_q   <= '0;
            xph_q        <= XWr;
            state_q      <= StPre;
          end
        end

        StFin: state_q <= StIdle;

        default: begin
          unique case (xph_q)
            XWr: begin
              if (abort_now && state_q != StPost) begin
                status       <= 3'd5;
                abort_pend_q <= 1'b0;
                state_q      <= StPost;
              end else if (!sh_in_full) begin
                sh_wr_req <= 1'b1;
                sh_wdata  <= tx_byte;
                xph_q     <= XRd;
              end
            end

            XRd: begin
              if (sh_out_full) begin
                sh_rd_req <= 1'b1;
                rx_q      <= sh_rdata;
                xph_q     <= XProc;
                if (state_q == StData) begin
                  buf_we    <= 1'b1;
                  buf_addr  <= data_cnt_q;
                  buf_wdata <= sh_rdata;
                end
              end
            end

            XProc: begin
              // sh_out_full is stale this cycle; the received byte is taken from rx_q.
              xph_q <= XWr;
              if (abort_now && state_q != StPost) begin
                status       <= 3'd5;
                abort_pend_q <= 1'b0;
                state_q      <= StPost;
              end else begin
                case (state_q)
                  StPre: begin
                    byte_cnt_q <= '0;
                    state_q    <= StCmd;
                  end
                  StCmd: begin
                    if (byte_cnt_q == 3'd5) begin
                      r1_cnt_q <= '0;
                      state_q  <= StR1;
                    end else begin
                      byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                  end
                  StR1: begin
                    if (!rx_q[7]) begin
                      r1 <= rx_q;
                      if (!rd_blk_q) begin
                        state_q <= StPost;
                      end else if (rx_q != 8'h00) begin
                        status  <= 3'd4;
                        state_q <= StPost;
                      end else begin
                        tok_cnt_q <= '0;
                        state_q   <= StToken;
                      end
                    end else if (r1_cnt_q == 4'(R1_POLL - 1)) begin
                      status  <= 3'd1;
                      state_q <= StPost;
                    end else begin
                      r1_cnt_q <= r1_cnt_q + 4'd1;
                    end
                  end
                  StToken: begin
                    if (rx_q == 8'hFE) begin
                      data_cnt_q <= '0;
                      state_q    <= StData;
                    end else if (rx_q[7:5] == 3'b000 && rx_q != 8'h00) begin
                      status  <= 3'd3;
                      state_q <= StPost;
                    end else if (tok_cnt_q == TOKEN_POLL - 16'd1) begin
                      status  <= 3'd2;
                      state_q <= StPost;
                    end else begin
                      tok_cnt_q <= tok_cnt_q + 16'd1;
                    end
                  end
                  StData: begin
                    if (data_cnt_q == 9'(BLOCK_BYTES - 1)) begin
                      byte_cnt_q <= '0;
                      state_q    <= StCrc;
                    end else begin
                      data_cnt_q <= data_cnt_q + 9'd1;
                    end
                  end
                  StCrc: begin
                    if (byte_cnt_q == 3'd0) begin
                      crc16[15:8] <= rx_q;
                      byte_cnt_q  <= 3'd1;
                    end else begin
                      crc16[7:0] <= rx_q;
                      state_q    <= StPost;
                    end
                  end
                  StPost: begin
                    ss_req  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StFin;
                  end
                  default: state_q <= StIdle;
                endcase
              end
            end

            default: xph_q <= XWr;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Hardware sequencer that drives the byte-wide SPI shifter to run one complete SD-card SPI-mode transaction without per-byte CPU involvement.
- A transaction is: command frame, R1 poll, and optionally a data-token wait plus a single-block read into a buffer write port.
- Sits between the sdcard register file and the shifter instance; the register file arbitrates shifter access (CPU vs sequencer) using `busy`.

Parameters:
- R1_POLL, 8: max bytes polled for R1 after the command frame.
- TOKEN_POLL, 16'd4096: max bytes polled for the data start token.
- BLOCK_BYTES, 512: data bytes per block.

Ports:
- clk  in  1  system clock (C100M domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transaction when idle
- abort  in  1  one-cycle pulse; terminates the transaction early
- cmd_index  in  6  SD command number
- cmd_arg  in  32  command argument, sent MSB first
- cmd_crc  in  7  CRC7 of the frame
- read_block  in  1  1 = expect a data block after R1
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse
- status  out  3  0 ok, 1 R1 timeout, 2 token timeout, 3 data error token, 4 R1 nonzero (read aborted), 5 aborted
- r1  out  8  captured R1 byte
- crc16  out  16  captured block CRC, not checked
- ss_req  out  1  request card slave select
- buf_we  out  1  buffer write strobe
- buf_addr  out  9  buffer byte address
- buf_wdata  out  8  buffer write data
- sh_wr_req  out  1  shifter TX push pulse
- sh_wdata  out  8  TX byte
- sh_rd_req  out  1  shifter RX pop pulse
- sh_in_full  in  1  shifter TX holding register full
- sh_out_full  in  1  shifter RX byte available
- sh_rdata  in  8  shifter RX byte

Behaviour:
- Reset: state IDLE; every output 0 except r1=8'hFF; status=0, crc16=0.
- Byte exchange (one byte in flight):
  - X_WR: wait for !sh_in_full, then pulse sh_wr_req for one cycle with sh_wdata.
  - X_RD: wait for sh_out_full, then pulse sh_rd_req for one cycle and latch sh_rdata.
  - sh_out_full is not re-sampled in the cycle after sh_rd_req.
- Poll and data bytes transmit 8'hFF.
- States: IDLE → PRE → CMD → R1 → (TOKEN → DATA → CRC) → POST → FIN → IDLE.
  - IDLE: start latches all cmd inputs; busy=1, ss_req=1.
  - PRE: exchange one 8'hFF.
  - CMD: 6 bytes, in order {2'b01,cmd_index}, arg[31:24], [23:16], [15:8], [7:0], {cmd_crc,1'b1}. Received bytes are discarded.
  - R1: poll until a received byte has bit7=0; capture it into r1.
    - If R1_POLL bytes arrive with no match: status=1, go to POST.
    - If read_block=0: go to POST.
    - If read_block=1 and r1≠0: status=4, go to POST.
  - TOKEN:
    - 8'hFE → DATA.
    - Byte with [7:5]=0 and nonzero → status=3, go to POST.
    - 8'hFF → keep polling.
    - Any other value counts as a poll byte.
    - TOKEN_POLL bytes without a token → status=2, go to POST.
  - DATA: BLOCK_BYTES exchanges. buf_we pulses in the cycle after each byte is latched; buf_addr runs 0..511; buf_wdata = received byte. The counter does not wrap past BLOCK_BYTES-1.
  - CRC: 2 bytes → crc16 {first, second}.
  - POST: exchange one 8'hFF with ss_req still high, then drop ss_req.
  - FIN: done pulses for one cycle and busy drops in the same cycle.
- start while busy is ignored.
- abort in any non-IDLE state:
  - Any pending X_RD still completes, so the shifter is drained.
  - Then status=5 and the sequencer goes to POST.
  - abort in IDLE has no effect.
- abort and a natural transition in the same cycle: abort wins.
- reset mid-transaction returns to IDLE immediately. The shifter's own reset is the caller's responsibility.
- Counters: R1 uses 4 bits and TOKEN uses 16 bits; both saturate at the limit, with no wrap-around.

Test Plan:
- CMD0: cmd_index=0, arg=0, crc=7'h4A, read_block=0; card answers FF,FF,01.
  - TX = FF,40,00,00,00,00,95,FF,FF,FF,FF.
  - r1=01, status=0, done once, ss_req low after the final byte.
- CMD17 read: arg=32'h00000200; R1=00, four FF bytes, then FE, bytes i&FF for i=0..511, CRC 12,34.
  - 512 buf_we pulses; addr 0..511 with data matching the sent pattern.
  - crc16=16'h1234, status=0.
- Card returns FF continuously after CMD: exactly 8 R1 poll bytes, then status=1, r1=FF, no buf_we.
- Error cases:
  - CMD17 with R1=05 → status=4, no TOKEN bytes sent.
  - R1=00 then token 08 → status=3.
- Stress:
  - Hold sh_in_full high for 20 cycles during CMD → no sh_wr_req while full; byte order is preserved.
  - Pulse abort at DATA byte 100 → buf_we count is 100 or 101, status=5, one trailing FF, done.
- Assert reset during TOKEN → next cycle busy=0, ss_req=0, no done pulse; a subsequent start runs normally.
